// File: rtl/huffman_bit_sender.sv
// Serial Huffman bitstream transmitter: per-character table lookup, length pulse, MSB-first code shift.
// Optional HUFF_TX_BIT_LAST_EN adds bit_last_o flagging the final bit of each codeword.
module huffman_bit_sender #(
   parameter int unsigned BIT_WIDTH = 8,
   parameter int unsigned LN_WIDTH  = 4,
   parameter int unsigned TB_WIDTH  = 11
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tbl_we_i,
   input  logic [BIT_WIDTH-1:0] tbl_char_i,
   input  logic [BIT_WIDTH-1:0] tbl_code_i,
   input  logic [LN_WIDTH-1:0]  tbl_len_i,
   input  logic                 start_i,
   input  logic [BIT_WIDTH-1:0] num_N_i,
   input  logic                 char_valid_i,
   input  logic [BIT_WIDTH-1:0] char_i,
   output logic                 char_ready_o,
   output logic                 ln_valid_o,
   output logic [LN_WIDTH-1:0]  ln_o,
   output logic                 bit_valid_o,
   output logic                 bit_o,
   input  logic                 bit_ready_i,
   output logic [TB_WIDTH-1:0]  total_bit_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
`ifdef HUFF_TX_BIT_LAST_EN
   ,
   output logic                 bit_last_o
`endif
);

   localparam int unsigned DEPTH = 1 << BIT_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOOKUP, S_SHIFT, S_DONE, S_ERROR
   } state_t;

   state_t               state_q;
   logic [BIT_WIDTH-1:0] code_q [DEPTH];
   logic [LN_WIDTH-1:0]  len_q  [DEPTH];
   logic [BIT_WIDTH-1:0] n_q, cnt_q, char_q, sr_q;
   logic [LN_WIDTH-1:0]  bitcnt_q, ln_q;
   logic [TB_WIDTH-1:0]  total_q;
   logic                 ready_q, ln_valid_q, bit_valid_q, busy_q, done_q, err_q;

   logic [BIT_WIDTH-1:0] lk_code;
   logic [LN_WIDTH-1:0]  lk_len;
   logic                 lk_bad, last_bit, tot_full;

   assign lk_code  = code_q[char_q];
   assign lk_len   = len_q[char_q];
   assign lk_bad   = (lk_len == '0) || (lk_len > LN_WIDTH'(BIT_WIDTH));
   assign last_bit = (bitcnt_q == LN_WIDTH'(1));
   assign tot_full = &total_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            code_q[i] <= '0;
            len_q[i]  <= '0;
         end
         n_q         <= '0;
         cnt_q       <= '0;
         char_q      <= '0;
         sr_q        <= '0;
         bitcnt_q    <= '0;
         ln_q        <= '0;
         total_q     <= '0;
         ready_q     <= 1'b0;
         ln_valid_q  <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         ln_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (state_q == S_IDLE && tbl_we_i) begin
                  code_q[tbl_char_i] <= tbl_code_i;
                  len_q[tbl_char_i]  <= tbl_len_i;
               end
               if (start_i) begin
                  n_q     <= num_N_i;
                  cnt_q   <= '0;
                  total_q <= '0;
                  err_q   <= 1'b0;
                  if (num_N_i == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                     done_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     ready_q <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (char_valid_i) begin
                  char_q  <= char_i;
                  cnt_q   <= cnt_q + 1'b1;
                  ready_q <= 1'b0;
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (lk_bad) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  sr_q        <= lk_code;
                  bitcnt_q    <= lk_len;
                  ln_q        <= lk_len;
                  ln_valid_q  <= 1'b1;
                  bit_valid_q <= 1'b1;
                  state_q     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_ready_i) begin
                  // Counter saturation aborts the message instead of wrapping.
                  if (tot_full) begin
                     state_q     <= S_ERROR;
                     err_q       <= 1'b1;
                     busy_q      <= 1'b0;
                     bit_valid_q <= 1'b0;
                     sr_q        <= '0;
                  end else begin
                     total_q  <= total_q + 1'b1;
                     bitcnt_q <= bitcnt_q - 1'b1;
                     if (last_bit) begin
                        bit_valid_q <= 1'b0;
                        sr_q        <= '0;
                        if (cnt_q == n_q) begin
                           state_q <= S_DONE;
                           done_q  <= 1'b1;
                           busy_q  <= 1'b0;
                        end else begin
                           state_q <= S_FETCH;
                           ready_q <= 1'b1;
                        end
                     end else begin
                        sr_q <= sr_q << 1;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign char_ready_o = ready_q;
   assign ln_valid_o   = ln_valid_q;
   assign ln_o         = ln_q;
   assign bit_valid_o  = bit_valid_q;
   assign bit_o        = sr_q[BIT_WIDTH-1];
   assign total_bit_o  = total_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
`ifdef HUFF_TX_BIT_LAST_EN
   assign bit_last_o   = bit_valid_q & last_bit;
`endif

endmodule

// File: tb/tb_huffman_bit_sender.sv
// Scoreboard bench for huffman_bit_sender; a second instance with a 3-bit total counter covers saturation.
module tb_huffman_bit_sender;

   logic       clk = 1'b0;
   logic       rst;
   logic       tbl_we;
   logic [7:0] tbl_char, tbl_code;
   logic [3:0] tbl_len;
   logic       start;
   logic [7:0] num_N;
   logic       char_valid;
   logic [7:0] chr;
   logic       bit_ready;

   logic        char_ready, ln_valid, bit_valid, bit_out, busy, done, err;
   logic [3:0]  ln;
   logic [10:0] total;
   logic        u2_char_ready, u2_ln_valid, u2_bit_valid, u2_bit_out, u2_busy, u2_done, u2_err;
   logic [3:0]  u2_ln;
   logic [2:0]  u2_total;
`ifdef HUFF_TX_BIT_LAST_EN
   logic        bit_last, u2_bit_last;
`endif

   huffman_bit_sender #(.BIT_WIDTH(8), .LN_WIDTH(4), .TB_WIDTH(11)) dut (
      .clk_i(clk), .rst_i(rst), .tbl_we_i(tbl_we), .tbl_char_i(tbl_char),
      .tbl_code_i(tbl_code), .tbl_len_i(tbl_len), .start_i(start), .num_N_i(num_N),
      .char_valid_i(char_valid), .char_i(chr), .char_ready_o(char_ready),
      .ln_valid_o(ln_valid), .ln_o(ln), .bit_valid_o(bit_valid), .bit_o(bit_out),
      .bit_ready_i(bit_ready), .total_bit_o(total), .busy_o(busy), .done_o(done),
      .err_o(err)
`ifdef HUFF_TX_BIT_LAST_EN
      , .bit_last_o(bit_last)
`endif
   );

   huffman_bit_sender #(.BIT_WIDTH(8), .LN_WIDTH(4), .TB_WIDTH(3)) dut_sat (
      .clk_i(clk), .rst_i(rst), .tbl_we_i(tbl_we), .tbl_char_i(tbl_char),
      .tbl_code_i(tbl_code), .tbl_len_i(tbl_len), .start_i(start), .num_N_i(num_N),
      .char_valid_i(char_valid), .char_i(chr), .char_ready_o(u2_char_ready),
      .ln_valid_o(u2_ln_valid), .ln_o(u2_ln), .bit_valid_o(u2_bit_valid), .bit_o(u2_bit_out),
      .bit_ready_i(bit_ready), .total_bit_o(u2_total), .busy_o(u2_busy), .done_o(u2_done),
      .err_o(u2_err)
`ifdef HUFF_TX_BIT_LAST_EN
      , .bit_last_o(u2_bit_last)
`endif
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   logic [7:0] m_code [256];
   logic [3:0] m_len  [256];
   bit         exp_bit_q [$];
   logic [3:0] exp_ln_q  [$];
   bit         exp_last_q [$];

   task automatic model_clear();
      for (int i = 0; i < 256; i++) begin
         m_code[i] = '0;
         m_len[i]  = '0;
      end
   endtask

   task automatic push_char(input logic [7:0] c);
      logic [7:0] code;
      int         len;
      code = m_code[c];
      len  = int'(m_len[c]);
      if (len != 0 && len <= 8) begin
         exp_ln_q.push_back(m_len[c]);
         for (int b = 0; b < len; b++) begin
            exp_bit_q.push_back(code[7-b]);
            exp_last_q.push_back(b == len - 1);
         end
      end
   endtask

   task automatic write_tbl(input logic [7:0] c, input logic [7:0] code, input logic [3:0] len);
      @(negedge clk);
      tbl_we = 1'b1; tbl_char = c; tbl_code = code; tbl_len = len;
      @(negedge clk);
      tbl_we = 1'b0;
      m_code[c] = code;
      m_len[c]  = len;
   endtask

   task automatic do_start(input logic [7:0] n);
      @(negedge clk);
      start = 1'b1; num_N = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // Drives a character list and scores ln/bit outputs against the model until done/err.
   task automatic drive_stream(input logic [7:0] chars [$], input bit toggle,
                               output int hs_cyc, output int first_cyc);
      int   idx = 0;
      int   cyc = 0;
      bit   fin = 1'b0;
      bit   stall_prev = 1'b0;
      logic held = 1'b0;
      bit   eb;
      logic [3:0] el;
      hs_cyc = -1; first_cyc = -1;
      exp_bit_q.delete(); exp_ln_q.delete(); exp_last_q.delete();
      while (!fin && cyc < 200) begin
         char_valid = (idx < chars.size());
         chr        = (idx < chars.size()) ? chars[idx] : 8'h00;
         bit_ready  = toggle ? (cyc % 2 == 1) : 1'b1;
         if (stall_prev) begin
            n_run++;
            if (bit_valid !== 1'b1 || bit_out !== held) begin
               n_fail++;
               $display("FAIL stall_hold: valid=%b bit=%b required valid=1 bit=%b", bit_valid, bit_out, held);
            end
         end
         if (ln_valid) begin
            n_run++;
            el = (exp_ln_q.size() != 0) ? exp_ln_q.pop_front() : 4'hx;
            if (ln !== el) begin
               n_fail++;
               $display("FAIL ln: got %0d required %0d", ln, el);
            end
         end
`ifdef HUFF_TX_BIT_LAST_EN
         if (bit_valid) begin
            n_run++;
            eb = (exp_last_q.size() != 0) ? exp_last_q[0] : 1'b0;
            if (bit_last !== eb) begin
               n_fail++;
               $display("FAIL bit_last: got %b required %b", bit_last, eb);
            end
         end
`endif
         if (bit_valid && first_cyc < 0) first_cyc = cyc;
         if (bit_valid && bit_ready) begin
            n_run++;
            if (exp_bit_q.size() == 0) begin
               n_fail++;
               $display("FAIL bit: got %b required no bit", bit_out);
            end else begin
               eb = exp_bit_q.pop_front();
               void'(exp_last_q.pop_front());
               if (bit_out !== eb) begin
                  n_fail++;
                  $display("FAIL bit: got %b required %b", bit_out, eb);
               end
            end
         end
         stall_prev = bit_valid && !bit_ready;
         held       = bit_out;
         if (char_valid && char_ready) begin
            push_char(chars[idx]);
            if (idx == 0) hs_cyc = cyc;
            idx++;
         end
         if (done || err) fin = 1'b1;
         @(negedge clk);
         cyc++;
      end
      char_valid = 1'b0;
      bit_ready  = 1'b1;
      n_run++;
      if (!fin) begin
         n_fail++;
         $display("FAIL stream_timeout: got no done/err required completion within 200 cycles");
      end
      n_run++;
      if (exp_bit_q.size() != 0 || exp_ln_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: got %0d bits %0d lens pending required 0", exp_bit_q.size(), exp_ln_q.size());
      end
   endtask

   task automatic test_reset();
      n_run++;
      if ({char_ready, ln_valid, ln, bit_valid, bit_out, total, busy, done, err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b lnv=%b ln=%0d bv=%b b=%b tot=%0d busy=%b done=%b err=%b required all 0",
                  char_ready, ln_valid, ln, bit_valid, bit_out, total, busy, done, err);
      end
   endtask

   task automatic test_basic(input bit toggle);
      logic [7:0] msg [$];
      int hs, fb;
      msg = '{8'h41, 8'h42, 8'h43};
      do_start(8'd3);
      drive_stream(msg, toggle, hs, fb);
      n_run++;
      if (fb - hs !== 2) begin
         n_fail++;
         $display("FAIL first_bit_latency: got %0d required 2", fb - hs);
      end
      n_run++;
      if (total !== 11'd5 || done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end: got tot=%0d done=%b busy=%b err=%b required 5 1 0 0", total, done, busy, err);
      end
   endtask

   task automatic test_bad_symbol();
      logic [7:0] msg [$];
      int hs, fb;
      msg = '{8'h41, 8'h44};
      do_start(8'd2);
      drive_stream(msg, 1'b0, hs, fb);
      n_run++;
      if (err !== 1'b1 || total !== 11'd1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_symbol: got err=%b tot=%0d done=%b required 1 1 0", err, total, done);
      end
      char_valid = 1'b1; chr = 8'h41;
      repeat (3) @(negedge clk);
      n_run++;
      if (char_ready !== 1'b0 || bit_valid !== 1'b0 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL error_hold: got rdy=%b bv=%b err=%b required 0 0 1", char_ready, bit_valid, err);
      end
      char_valid = 1'b0;
   endtask

   task automatic test_zero_n();
      do_start(8'd0);
      n_run++;
      if (done !== 1'b1 || err !== 1'b0 || total !== 11'd0 || ln_valid !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_n: got done=%b err=%b tot=%0d lnv=%b bv=%b busy=%b required 1 0 0 0 0 0",
                  done, err, total, ln_valid, bit_valid, busy);
      end
   endtask

   task automatic stall_in_shift();
      int k = 0;
      do_start(8'd1);
      char_valid = 1'b1; chr = 8'h42; bit_ready = 1'b0;
      while (!bit_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      char_valid = 1'b0;
      n_run++;
      if (bit_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reach_shift: got bit_valid=%b required 1", bit_valid);
      end
   endtask

   task automatic test_write_and_reset_midop();
      logic [7:0] msg [$];
      int hs, fb, k;
      stall_in_shift();
      tbl_we = 1'b1; tbl_char = 8'h41; tbl_code = 8'hFF; tbl_len = 4'd3;
      @(negedge clk);
      tbl_we = 1'b0;
      bit_ready = 1'b1;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_run++;
      if (done !== 1'b1 || total !== 11'd2) begin
         n_fail++;
         $display("FAIL shift_complete: got done=%b tot=%0d required 1 2", done, total);
      end
      msg = '{8'h41};
      do_start(8'd1);
      drive_stream(msg, 1'b0, hs, fb);
      n_run++;
      if (done !== 1'b1 || total !== 11'd1) begin
         n_fail++;
         $display("FAIL write_ignored: got done=%b tot=%0d required 1 1", done, total);
      end
      stall_in_shift();
      rst = 1'b1;
      #1;
      n_run++;
      if ({char_ready, ln_valid, ln, bit_valid, bit_out, total, busy, done, err} !== '0) begin
         n_fail++;
         $display("FAIL midop_reset: got rdy=%b lnv=%b ln=%0d bv=%b b=%b tot=%0d busy=%b done=%b err=%b required all 0",
                  char_ready, ln_valid, ln, bit_valid, bit_out, total, busy, done, err);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      do_start(8'd1);
      drive_stream(msg, 1'b0, hs, fb);
      n_run++;
      if (err !== 1'b1 || total !== 11'd0) begin
         n_fail++;
         $display("FAIL table_cleared: got err=%b tot=%0d required 1 0", err, total);
      end
   endtask

   task automatic test_saturation();
      int k = 0;
      pulse_reset();
      write_tbl(8'h42, 8'h80, 4'd2);
      do_start(8'd4);
      char_valid = 1'b1; chr = 8'h42; bit_ready = 1'b1;
      while (!(u2_err && done) && k < 60) begin
         @(negedge clk);
         k++;
      end
      char_valid = 1'b0;
      n_run++;
      if (u2_err !== 1'b1 || u2_total !== 3'd7 || u2_done !== 1'b0 || u2_bit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL total_saturate: got err=%b tot=%0d done=%b bv=%b required 1 7 0 0",
                  u2_err, u2_total, u2_done, u2_bit_valid);
      end
      n_run++;
      if (done !== 1'b1 || total !== 11'd8 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_total: got done=%b tot=%0d err=%b required 1 8 0", done, total, err);
      end
   endtask

   initial begin
      rst = 1'b1; tbl_we = 1'b0; tbl_char = '0; tbl_code = '0; tbl_len = '0;
      start = 1'b0; num_N = '0; char_valid = 1'b0; chr = '0; bit_ready = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      write_tbl(8'h41, 8'h00, 4'd1);
      write_tbl(8'h42, 8'h80, 4'd2);
      write_tbl(8'h43, 8'hC0, 4'd2);
      test_basic(1'b0);
      test_basic(1'b1);
      test_bad_symbol();
      test_zero_n();
      test_write_and_reset_midop();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
